alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issuing front-end for the processor's combinational 32-bit ALU. Accepts an operation request (ALUOp, funct, two operands) over a valid/ready handshake, encodes it into the ALU's 4-bit control code, drives the ALU with registered operands, then captures result and zero flag into a held response. It sits between instruction decode and the ALU and is the only block that drives ALU control.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_aluop  input  2  00 add, 01 sub, 10 R-type by funct, 11 OR
- req_funct  input  6  R-type funct field; used only when req_aluop=10
- req_a  input  32  operand rs
- req_b  input  32  operand rt or immediate
- alu_a  output  32  registered ALU operand A
- alu_b  output  32  registered ALU operand B
- alu_ctrl  output  4  registered ALU control code
- alu_y  input  32  ALU result; combinational from alu_a/alu_b/alu_ctrl
- alu_zero  input  1  ALU zero flag
- rsp_valid  output  1  response held
- rsp_ready  input  1  consumer takes response
- rsp_y  output  32  captured result
- rsp_zero  output  1  captured zero flag
- rsp_err  output  1  illegal funct flag; see Configuration

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: req_ready=1. On req_valid, go ISSUE and register operands and control.
- ISSUE: req_ready=0. ALU settles. Go RESP and capture alu_y into rsp_y, alu_zero into rsp_zero, and the illegal flag into rsp_err.
- RESP: rsp_valid=1. rsp_* remain stable until rsp_ready=1, then go IDLE.
- Encoding: aluop 00→0010, 01→0110, 11→0001.
- R-type funct encoding (aluop 10): 100000→0010, 100010→0110, 100100→0000, 100101→0001, 100111→1100, 101010→0111, 000100→0100 (SLLV). Any other funct→1111 and is illegal.
- Operands for all operations except SLLV: alu_a=req_a, alu_b=req_b.
- SLLV operands: alu_a=req_b, alu_b={27'b0, req_a[4:0]}. This gives MIPS semantics: rt shifted by rs[4:0].
- Illegal funct: the ALU is still issued with 1111, so its result is 0 and its zero flag is 1.
- Inputs are ignored outside IDLE. req_* need be stable only during the accept cycle.

## Timing
- Reset (async assert, sync-released): state IDLE; req_ready=1; rsp_valid=0; alu_a, alu_b, rsp_y=0; alu_ctrl=0000; rsp_zero=0; rsp_err=0.
- Request accepted at edge k (req_valid & req_ready). alu_* are valid after edge k. rsp_valid=1 after edge k+1.
- Response consumed at edge m (rsp_valid & rsp_ready). req_ready=1 after edge m. Minimum request-to-request spacing is 3 cycles.
- rsp_ready high before rsp_valid has no effect.
- rsp_ready held high continuously gives RESP a single-cycle dwell.
- Reset mid-ISSUE or mid-RESP: the transaction is dropped, all outputs take their reset values immediately, and no response is produced.
- alu_* hold their last values in RESP and IDLE until the next accept.

## Configuration
- ALU_ISSUE_ERR_EN defined: illegal-funct detection is active and rsp_err reports it with the response.
- ALU_ISSUE_ERR_EN undefined: rsp_err is tied 0 and the detection logic is removed. Illegal funct still encodes to 1111.

## Structure
- Package alu_issue_pkg holds:
  - ALU control code constants (AND, OR, ADD, SUB, SLT, NOR, SLLV, ILLEGAL=1111)
  - ALUOp constants
  - R-type funct constants
  - state enum
- Sub-module alu_ctrl_decode is a combinational encoder: (aluop, funct) → (ctrl[3:0], illegal, swap_shift). It is instantiated once, on the req_* side.

## Test plan
- Reset mid-ISSUE: assert rst_n=0 → rsp_valid=0 and req_ready=1 immediately, and no response follows release.
- ADD: aluop 10, funct 100000, a=5, b=7 → alu_ctrl=0010 after accept, rsp_y=12, rsp_zero=0, rsp_valid two edges after accept.
- SUB zero: aluop 01, a=b=0x1234 → rsp_y=0, rsp_zero=1.
- SLT signed: aluop 10, funct 101010, a=0xFFFFFFFF, b=1 → rsp_y=1.
- SLLV swap: aluop 10, funct 000100, a=0x24, b=1 → alu_a=1, alu_b=4, rsp_y=0x10.
- Illegal plus backpressure: aluop 10, funct 111111, rsp_ready low for 5 cycles → rsp_ctrl path 1111, rsp_y=0, rsp_zero=1, rsp_err=1 (0 without ALU_ISSUE_ERR_EN). Outputs are held stable and req_ready=0 throughout.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue front-end: control codes,
// ALUOp values, R-type funct values and the issue FSM state encoding.
package alu_issue_pkg;

  localparam int unsigned DATA_W = 32;

  // ALU control codes
  localparam logic [3:0] CTRL_AND     = 4'b0000;
  localparam logic [3:0] CTRL_OR      = 4'b0001;
  localparam logic [3:0] CTRL_ADD     = 4'b0010;
  localparam logic [3:0] CTRL_SLLV    = 4'b0100;
  localparam logic [3:0] CTRL_SUB     = 4'b0110;
  localparam logic [3:0] CTRL_SLT     = 4'b0111;
  localparam logic [3:0] CTRL_NOR     = 4'b1100;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  // ALUOp field from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  // Maps an R-type funct to its control code; unknown functs give CTRL_ILLEGAL.
  function automatic logic [3:0] funct_to_ctrl(input logic [5:0] funct);
    logic [3:0] ctrl;
    case (funct)
      FUNCT_ADD:  ctrl = CTRL_ADD;
      FUNCT_SUB:  ctrl = CTRL_SUB;
      FUNCT_AND:  ctrl = CTRL_AND;
      FUNCT_OR:   ctrl = CTRL_OR;
      FUNCT_NOR:  ctrl = CTRL_NOR;
      FUNCT_SLT:  ctrl = CTRL_SLT;
      FUNCT_SLLV: ctrl = CTRL_SLLV;
      default:    ctrl = CTRL_ILLEGAL;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational encoder from (ALUOp, funct) to the 4-bit ALU control code.
// The illegal-funct output exists only when ALU_ISSUE_ERR_EN is defined.
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
`ifdef ALU_ISSUE_ERR_EN
  output logic       o_illegal,
`endif
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_ctrl,
  output logic       o_swap_shift
);

  always_comb begin
    o_ctrl = CTRL_ILLEGAL;
    case (i_aluop)
      ALUOP_ADD:   o_ctrl = CTRL_ADD;
      ALUOP_SUB:   o_ctrl = CTRL_SUB;
      ALUOP_RTYPE: o_ctrl = funct_to_ctrl(i_funct);
      ALUOP_OR:    o_ctrl = CTRL_OR;
      default:     o_ctrl = CTRL_ILLEGAL;
    endcase
  end

  // SLLV takes rt as the shifted value and rs[4:0] as the amount
  assign o_swap_shift = (i_aluop == ALUOP_RTYPE) && (i_funct == FUNCT_SLLV);

`ifdef ALU_ISSUE_ERR_EN
  // Only the R-type path can produce the illegal code
  assign o_illegal = (i_aluop == ALUOP_RTYPE) && (o_ctrl == CTRL_ILLEGAL);
`endif

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issuing front-end for the combinational 32-bit ALU: accept, issue, respond.
// Optional illegal-funct reporting on rsp_err is enabled by ALU_ISSUE_ERR_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_y,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic        rsp_zero,
  output logic        rsp_err
);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_ctrl;
  logic [31:0] r_rsp_y;
  logic        r_rsp_zero;

  logic [3:0]  w_ctrl;
  logic        w_swap_shift;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;

`ifdef ALU_ISSUE_ERR_EN
  logic w_illegal;
  logic r_illegal;
  logic r_rsp_err;
`endif

  alu_ctrl_decode u_decode (
`ifdef ALU_ISSUE_ERR_EN
    .o_illegal    (w_illegal),
`endif
    .i_aluop      (req_aluop),
    .i_funct      (req_funct),
    .o_ctrl       (w_ctrl),
    .o_swap_shift (w_swap_shift)
  );

  assign w_op_a = w_swap_shift ? req_b : req_a;
  assign w_op_b = w_swap_shift ? {27'b0, req_a[4:0]} : req_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= CTRL_AND;
      r_rsp_y     <= '0;
      r_rsp_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_alu_a     <= w_op_a;
            r_alu_b     <= w_op_b;
            r_alu_ctrl  <= w_ctrl;
            r_req_ready <= 1'b0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ALU has had a full cycle to settle on the registered operands
          r_rsp_y     <= alu_y;
          r_rsp_zero  <= alu_zero;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_illegal <= w_illegal;
      end
      if (r_state == ST_ISSUE) begin
        r_rsp_err <= r_illegal;
      end
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_ctrl  = r_alu_ctrl;
  assign rsp_y     = r_rsp_y;
  assign rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the alu_* side.
// Set ALU_ISSUE_ERR_EN consistently for bench and RTL to check rsp_err.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_zero, rsp_err;

  int checks = 0;
  int errors = 0;
  logic exp_ill_err;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Reference ALU driven by the DUT's registered control outputs
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_y = alu_a & alu_b;
      4'b0001: alu_y = alu_a | alu_b;
      4'b0010: alu_y = alu_a + alu_b;
      4'b0110: alu_y = alu_a - alu_b;
      4'b0111: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_y = ~(alu_a | alu_b);
      4'b0100: alu_y = alu_a << alu_b[4:0];
      default: alu_y = 32'd0;
    endcase
    alu_zero = (alu_y == 32'd0);
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue_req(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_aluop = op; req_funct = fn; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_aluop = 2'b11; req_funct = 6'h3F;
    req_a = 32'hDEADBEEF; req_b = 32'hCAFEF00D;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 1'b0; req_aluop = '0; req_funct = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'b0000) begin
      errors++; $display("FAIL reset_alu: a=%h b=%h ctrl=%b required 0 0 0000", alu_a, alu_b, alu_ctrl);
    end
    checks++;
    if (rsp_y !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: y=%h zero=%b err=%b required 0 0 0", rsp_y, rsp_zero, rsp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: req_ready=%b rsp_valid=%b", req_ready, rsp_valid);
  endtask

  task automatic test_add();
    issue_req(2'b10, 6'b100000, 32'd5, 32'd7);
    checks++;
    if (alu_ctrl !== 4'b0010 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_issue: ctrl=%b req_ready=%b rsp_valid=%b required 0010 0 0", alu_ctrl, req_ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 32'd12 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL add_rsp: valid=%b y=%h zero=%b required 1 0000000c 0", rsp_valid, rsp_y, rsp_zero);
    end
    $display("add: a=5 b=7 y=%0d zero=%b", rsp_y, rsp_zero);
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL add_consume: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_sub_zero();
    issue_req(2'b01, 6'b000000, 32'h1234, 32'h1234);
    checks++;
    if (alu_ctrl !== 4'b0110) begin
      errors++; $display("FAIL sub_ctrl: ctrl=%b required 0110", alu_ctrl);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 32'd0 || rsp_zero !== 1'b1) begin
      errors++; $display("FAIL sub_rsp: valid=%b y=%h zero=%b required 1 0 1", rsp_valid, rsp_y, rsp_zero);
    end
    $display("sub: a=b=0x1234 y=%h zero=%b", rsp_y, rsp_zero);
    consume();
  endtask

  task automatic test_slt_signed();
    issue_req(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (alu_ctrl !== 4'b0111 || alu_a !== 32'hFFFFFFFF || alu_b !== 32'd1) begin
      errors++; $display("FAIL slt_issue: ctrl=%b a=%h b=%h required 0111 ffffffff 1", alu_ctrl, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (rsp_y !== 32'd1 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL slt_rsp: y=%h zero=%b required 1 0", rsp_y, rsp_zero);
    end
    $display("slt: a=-1 b=1 y=%0d", rsp_y);
    consume();
  endtask

  task automatic test_sllv_swap();
    issue_req(2'b10, 6'b000100, 32'h24, 32'd1);
    checks++;
    if (alu_a !== 32'd1 || alu_b !== 32'd4 || alu_ctrl !== 4'b0100) begin
      errors++; $display("FAIL sllv_ops: a=%h b=%h ctrl=%b required 1 4 0100", alu_a, alu_b, alu_ctrl);
    end
    @(negedge clk);
    checks++;
    if (rsp_y !== 32'h10) begin
      errors++; $display("FAIL sllv_rsp: y=%h required 10", rsp_y);
    end
    $display("sllv: rs=0x24 rt=1 y=%h", rsp_y);
    consume();
  endtask

  task automatic test_illegal_backpressure();
    issue_req(2'b10, 6'b111111, 32'h55, 32'hAA);
    checks++;
    if (alu_ctrl !== 4'b1111) begin
      errors++; $display("FAIL ill_ctrl: ctrl=%b required 1111", alu_ctrl);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_y !== 32'd0 ||
          rsp_zero !== 1'b1 || rsp_err !== exp_ill_err) begin
        errors++;
        $display("FAIL ill_hold[%0d]: valid=%b ready=%b y=%h zero=%b err=%b required 1 0 0 1 %b",
                 i, rsp_valid, req_ready, rsp_y, rsp_zero, rsp_err, exp_ill_err);
      end
      @(negedge clk);
    end
    $display("illegal: y=%h zero=%b err=%b after 5 stalled cycles", rsp_y, rsp_zero, rsp_err);
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL ill_consume: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL early_ready: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
    issue_req(2'b11, 6'b000000, 32'hF0, 32'h0F);
    // Request held during ISSUE must be ignored
    req_valid = 1'b1; req_aluop = 2'b00; req_a = 32'd1; req_b = 32'd2;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 32'hFF || alu_ctrl !== 4'b0001 || alu_a !== 32'hF0) begin
      errors++; $display("FAIL b2b_first: valid=%b y=%h ctrl=%b a=%h required 1 ff 0001 f0", rsp_valid, rsp_y, alu_ctrl, alu_a);
    end
    $display("or: a=0xf0 b=0x0f y=%h", rsp_y);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_a !== 32'hF0) begin
      errors++; $display("FAIL b2b_dwell: rsp_valid=%b req_ready=%b alu_a=%h required 0 1 f0", rsp_valid, req_ready, alu_a);
    end
    issue_req(2'b10, 6'b100111, 32'h0, 32'hFFFF0000);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 32'h0000FFFF || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL b2b_nor: valid=%b y=%h zero=%b required 1 0000ffff 0", rsp_valid, rsp_y, rsp_zero);
    end
    $display("nor: a=0 b=0xffff0000 y=%h", rsp_y);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid(input bit in_resp);
    logic seen_valid;
    issue_req(2'b10, 6'b100100, 32'hF0F0, 32'hFF00);
    if (in_resp) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_ctrl !== 4'b0000 ||
        alu_a !== 32'd0 || rsp_y !== 32'd0) begin
      errors++; $display("FAIL rst_mid%0d: valid=%b ready=%b ctrl=%b a=%h y=%h required 0 1 0000 0 0",
                         in_resp, rsp_valid, req_ready, alu_ctrl, alu_a, rsp_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid%0d_after: rsp_valid_seen=%b req_ready=%b required 0 1", in_resp, seen_valid, req_ready);
    end
    $display("reset mid-%s: transaction dropped", in_resp ? "RESP" : "ISSUE");
  endtask

  initial begin
`ifdef ALU_ISSUE_ERR_EN
    exp_ill_err = 1'b1;
`else
    exp_ill_err = 1'b0;
`endif
    test_reset();
    test_reset_mid(1'b0);
    test_add();
    test_sub_zero();
    test_slt_signed();
    test_sllv_swap();
    test_illegal_backpressure();
    test_back_to_back();
    test_reset_mid(1'b1);
    test_add();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
